// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_regfile.sv
// Working registers of the restoring divider: partial remainder A (WIDTH+1 bits),
// quotient/dividend shifter Q and divisor M, with load-start and load-step controls.
module div_regfile
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load_start,
    input  logic             i_load_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic [WIDTH:0]   i_a_next,
    input  logic [WIDTH-1:0] i_q_next,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_m
);

    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;

    // A load always wins over a step; the controller never asserts both.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a <= '0;
            r_q <= '0;
            r_m <= '0;
        end else if (i_load_start) begin
            r_a <= '0;
            r_q <= i_dividend;
            r_m <= i_divisor;
        end else if (i_load_step) begin
            r_a <= i_a_next;
            r_q <= i_q_next;
        end
    end

    assign o_a = r_a;
    assign o_q = r_q;
    assign o_m = r_m;

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock).
// Optional signed operation is enabled by defining RESTORING_DIVIDER_SIGNED_EN.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
`ifdef RESTORING_DIVIDER_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output div_state_e       dbg_state
);

    // Handshake: start is taken only in IDLE (operands sampled on that edge); busy is
    // high from the next cycle until the result cycle; done pulses one cycle with the
    // results, which then hold until the next completed division. No queuing.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    div_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_load_start;
    logic             w_load_step;
    logic [WIDTH-1:0] w_ld_dividend;
    logic [WIDTH-1:0] w_ld_divisor;
    logic [WIDTH:0]   w_a;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_m;
    logic [WIDTH+1:0] w_a_shift;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH:0]   w_a_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_a_lo;
    logic             w_m_zero;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_load_start = (r_state == S_IDLE) && start;
    assign w_load_step  = (r_state == S_RUN) && (r_cnt != LAST);

`ifdef RESTORING_DIVIDER_SIGNED_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_neg_q;
    logic r_neg_r;

    // Magnitudes are loaded; signs are reapplied when the result is captured.
    assign w_neg_a       = signed_mode && dividend[WIDTH-1];
    assign w_neg_b       = signed_mode && divisor[WIDTH-1];
    assign w_ld_dividend = w_neg_a ? -dividend : dividend;
    assign w_ld_divisor  = w_neg_b ? -divisor : divisor;
`else
    assign w_ld_dividend = dividend;
    assign w_ld_divisor  = divisor;
`endif

    div_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk          (clk),
        .rstn         (rstn),
        .i_load_start (w_load_start),
        .i_load_step  (w_load_step),
        .i_dividend   (w_ld_dividend),
        .i_divisor    (w_ld_divisor),
        .i_a_next     (w_a_next),
        .i_q_next     (w_q_next),
        .o_a          (w_a),
        .o_q          (w_q),
        .o_m          (w_m)
    );

    // One extra guard bit keeps the borrow visible as the sign of the difference.
    assign w_a_shift = {w_a, w_q[WIDTH-1]};
    assign w_diff    = w_a_shift - {2'b00, w_m};
    assign w_a_next  = w_diff[WIDTH+1] ? w_a_shift[WIDTH:0] : w_diff[WIDTH:0];
    assign w_q_next  = {w_q[WIDTH-2:0], ~w_diff[WIDTH+1]};

    assign w_a_lo   = w_a[WIDTH-1:0];
    assign w_m_zero = (w_m == '0);

`ifdef RESTORING_DIVIDER_SIGNED_EN
    // A zero divisor keeps the raw all-ones quotient regardless of operand signs.
    assign w_quo = (r_neg_q && !w_m_zero) ? -w_q : w_q;
    assign w_rem = r_neg_r ? -w_a_lo : w_a_lo;
`else
    assign w_quo = w_q;
    assign w_rem = w_a_lo;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
`endif
                    end
                end
                S_RUN: begin
                    if (r_cnt == LAST) begin
                        r_state       <= S_DONE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_quotient    <= w_quo;
                        r_remainder   <= w_rem;
                        r_div_by_zero <= w_m_zero;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign dbg_state   = r_state;

endmodule
